datmem_pipe: RTL
================

# datmem_pipe

Parametrised synchronous data memory that replaces the combinational data memory on the processor's load/store path. It is clocked, has a req/ready handshake and a configurable 1- or 2-stage registered read pipeline. After every reset it runs a hardware clear sequence that zeroes all words before accepting traffic. It sits between the execute stage and the register-file write-back.

## Interface

Parameters:
- DW, 16, data word width in bits
- AW, 8, address width; depth = 2^AW words
- RDLAT, 1, read latency in cycles; legal values 1 or 2

Ports:
- clk  in  1  system clock, rising edge; single clock domain
- rst  in  1  asynchronous, active-high reset
- req  in  1  request valid
- rwb  in  1  1 = write, 0 = read
- dadd  in  AW  word address
- din  in  DW  write data
- ready  out  1  block accepts a request this cycle
- dout  out  DW  read data, registered
- dvalid  out  1  one-cycle pulse: dout carries a new read result

## Operation

- The FSM has two states:
  - INIT: entered on rst. An internal AW-bit counter starts at 0. Each clock writes 0 to mem[counter] and increments the counter. After the write to address 2^AW−1, the FSM moves to RUN.
  - RUN: the normal operating state.
- A request is accepted on a rising edge where req=1 and ready=1. ready = (state==RUN). A req presented while ready=0 is ignored, not queued; the requester must hold it.
- Write (rwb=1): mem[dadd] <= din at the accepting edge. No read response; dvalid stays 0.
- Read (rwb=0): the read returns mem[dadd] as it stands after the accepting edge. This value is captured into the pipeline at that edge. A later write to the same address does not alter a read already accepted.
- One request is accepted per cycle. Back-to-back reads, writes and mixes are allowed at full rate.
- dout holds its last read value until the next read completes; writes never change dout.
- Width rules:
  - dadd is used in full; there is no out-of-range address.
  - The clear counter wraps 2^AW−1 → 0 only at the INIT→RUN exit. It is not used in RUN.

## Timing

- Reset values, asynchronous on rst=1:
  - state = INIT, counter = 0
  - ready = 0, dvalid = 0, dout = 0
  - all read-pipeline valid bits = 0
- Memory contents are not reset asynchronously; they are only zeroed by the INIT sequence.
- INIT duration: the first rising edge with rst=0 clears address 0. ready goes to 1 after the edge that clears address 2^AW−1, i.e. 2^AW edges after rst is released (256 for AW=8).
- Read latency, where E is the accepting edge:
  - RDLAT=1: dout and dvalid update at edge E+1.
  - RDLAT=2: dout and dvalid update at edge E+2.
- A write at edge E followed by a read of the same address accepted at E+1 returns the new data.
- Reset mid-operation:
  - In-flight reads are discarded; no dvalid pulse is issued for them.
  - dout is forced to 0.
  - INIT restarts from address 0. A partially completed earlier INIT has no effect.
- rst asserted for a single cycle is sufficient; the full clear sequence still runs.

## Test plan

- Reset/init, AW=4: assert rst, release it. ready=0 for 16 edges, then 1. A read of each address 0..15 returns 0x0000 with dvalid, and dout=0 throughout INIT.
- Write then read, RDLAT=1: write 0xBEEF to 0x12, then read 0x12 on the next cycle. dout=0xBEEF with dvalid=1 exactly one edge after the read is accepted.
- Pipelined reads, RDLAT=2: preload 0x00=0x1111, 0x01=0x2222, 0xFF=0x3333. Issue reads 0x00, 0x01, 0xFF on consecutive cycles. dvalid is high for 3 consecutive cycles starting 2 edges after the first accept, with dout = 0x1111, 0x2222, 0x3333 in order.
- Read-before-write ordering, RDLAT=2: mem[5]=0x00AA. Read 5, then immediately write 0x0055 to 5. The read returns 0x00AA; a second read of 5 returns 0x0055.
- Request during INIT: hold req=1 with a write of 0xFFFF to 0x03 during INIT. No write occurs, and after ready rises a read of 0x03 returns 0x0000 if req was dropped first.
- Reset mid-read, RDLAT=2: accept a read, then assert rst one cycle later. No dvalid pulse is seen, dout=0, and ready stays 0 for a full 2^AW-edge INIT.

Source files
------------

// File: rtl/datmem_pipe.sv
// Synchronous data memory with req/ready handshake, 1- or 2-stage registered
// read pipeline, and a post-reset clear sequence that zeroes every word.
module datmem_pipe #(
  parameter int DW    = 16,
  parameter int AW    = 8,
  parameter int RDLAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic          rwb,
  input  logic [AW-1:0] dadd,
  input  logic [DW-1:0] din,
  output logic          ready,
  output logic [DW-1:0] dout,
  output logic          dvalid
);

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] cnt;
  logic          clear_en;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  logic          accept;
  logic          rd_acc;
  logic          mem_we;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  logic          s1_valid;
  logic          s2_valid;
  logic [DW-1:0] s1_data;
  logic [DW-1:0] s2_data;
  logic          last_valid;
  logic [DW-1:0] last_data;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= INIT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: leave INIT right after the last word has been cleared.
  always_comb begin
    state_nxt = state;
    case (state)
      INIT:    if (cnt == {AW{1'b1}}) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = INIT;
    endcase
  end

  // FSM outputs.
  always_comb begin
    ready    = 1'b0;
    clear_en = 1'b0;
    case (state)
      INIT:    clear_en = 1'b1;
      RUN:     ready    = 1'b1;
      default: clear_en = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear_en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign accept  = req && ready;
  assign rd_acc  = accept && !rwb;
  assign mem_we  = clear_en || (accept && rwb);
  assign wr_addr = clear_en ? cnt : dadd;
  assign wr_data = clear_en ? '0 : din;

  // Storage and data stages carry no reset so they can map onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_acc) begin
      s1_data <= mem[dadd];
    end
    s2_data <= s1_data;
  end

  assign last_valid = (RDLAT == 2) ? s2_valid : s1_valid;
  assign last_data  = (RDLAT == 2) ? s2_data  : s1_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      dvalid   <= 1'b0;
      dout     <= '0;
    end else begin
      s1_valid <= rd_acc;
      s2_valid <= s1_valid;
      dvalid   <= last_valid;
      if (last_valid) begin
        dout <= last_data;
      end
    end
  end

endmodule
